// File: rtl/soc_sonhamos_pkg.sv
// Shared constants and types for the CGRA external-slave arbitration path.
package soc_sonhamos_pkg;

  localparam int CGRA_XBAR_NMASTER    = 8;
  localparam int CGRA_MAX_OUTSTANDING = 4;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cgra_ext_slave_arbiter_if.sv
// OBI bundle between the CGRA masters, the shared-slave arbiter and the external slave.
interface cgra_ext_slave_arbiter_if #(
  parameter int NMASTER = soc_sonhamos_pkg::CGRA_XBAR_NMASTER
);

  logic [NMASTER-1:0]       m_req_i;
  logic [NMASTER-1:0]       m_gnt_o;
  logic [NMASTER-1:0][31:0] m_addr_i;
  logic [NMASTER-1:0][31:0] m_wdata_i;
  logic [NMASTER-1:0][3:0]  m_be_i;
  logic [NMASTER-1:0]       m_we_i;
  logic [NMASTER-1:0]       m_rvalid_o;
  logic [NMASTER-1:0][31:0] m_rdata_o;

  logic                     s_req_o;
  logic [31:0]              s_addr_o;
  logic [31:0]              s_wdata_o;
  logic [3:0]               s_be_o;
  logic                     s_we_o;
  logic                     s_gnt_i;
  logic                     s_rvalid_i;
  logic [31:0]              s_rdata_i;

  // Arbiter side of the bundle.
  modport slave (
    input  m_req_i, m_addr_i, m_wdata_i, m_be_i, m_we_i,
    input  s_gnt_i, s_rvalid_i, s_rdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o,
    output s_req_o, s_addr_o, s_wdata_o, s_be_o, s_we_o
  );

  // Environment side: the masters and the external slave together.
  modport master (
    output m_req_i, m_addr_i, m_wdata_i, m_be_i, m_we_i,
    output s_gnt_i, s_rvalid_i, s_rdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o,
    input  s_req_o, s_addr_o, s_wdata_o, s_be_o, s_we_o
  );

endinterface

// File: rtl/cgra_arb_id_fifo.sv
// In-order FIFO of granted master indices; the head names who owns the next response.
module cgra_arb_id_fifo #(
  parameter int  WIDTH = 3,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wrap_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= wrap_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/cgra_ext_slave_arbiter.sv
// Round-robin arbiter sharing one OBI slave among the CGRA masters, with in-order
// response routing through an ID FIFO.
module cgra_ext_slave_arbiter
  import soc_sonhamos_pkg::*;
#(
  parameter int  NMASTER         = CGRA_XBAR_NMASTER,
  parameter int  MAX_OUTSTANDING = CGRA_MAX_OUTSTANDING,
  localparam int IDW             = idx_width(NMASTER),
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  cgra_ext_slave_arbiter_if.slave bus,
  output logic [CW-1:0]           outstanding_o,
  output logic                    err_o
);

  arb_state_e     state_reg;
  logic [IDW-1:0] rr_ptr_reg;
  logic [IDW-1:0] locked_idx_reg;
  logic           err_reg;

  logic [IDW:0]   cand;
  logic [IDW-1:0] rr_winner;
  logic           rr_found;
  logic [IDW-1:0] sel_idx;
  logic [IDW-1:0] next_ptr;
  logic           req_valid;
  logic           s_req;
  logic           grant;
  logic           rsp_valid;
  logic [IDW-1:0] head_idx;
  logic           fifo_full;
  logic           fifo_empty;

  always_comb begin
    cand      = '0;
    rr_winner = '0;
    rr_found  = 1'b0;
    for (int i = 0; i < NMASTER; i++) begin
      cand = {1'b0, rr_ptr_reg} + (IDW + 1)'(i);
      if (cand >= (IDW + 1)'(NMASTER)) cand = cand - (IDW + 1)'(NMASTER);
      if (!rr_found && bus.m_req_i[cand[IDW-1:0]]) begin
        rr_winner = cand[IDW-1:0];
        rr_found  = 1'b1;
      end
    end
  end

  // A stalled request keeps its master on the bus until the slave accepts it.
  always_comb begin
    sel_idx   = (state_reg == LOCKED) ? locked_idx_reg : rr_winner;
    req_valid = (state_reg == LOCKED) ? bus.m_req_i[locked_idx_reg] : rr_found;
    s_req     = req_valid & ~fifo_full & ~rst_i;
    next_ptr  = (sel_idx == IDW'(NMASTER - 1)) ? '0 : sel_idx + 1'b1;
  end

  assign grant     = s_req & bus.s_gnt_i;
  assign rsp_valid = bus.s_rvalid_i & ~fifo_empty & ~rst_i;

  assign bus.s_req_o   = s_req;
  assign bus.s_addr_o  = s_req ? bus.m_addr_i[sel_idx]  : '0;
  assign bus.s_wdata_o = s_req ? bus.m_wdata_i[sel_idx] : '0;
  assign bus.s_be_o    = s_req ? bus.m_be_i[sel_idx]    : '0;
  assign bus.s_we_o    = s_req & bus.m_we_i[sel_idx];

  for (genvar gi = 0; gi < NMASTER; gi++) begin : g_route
    assign bus.m_gnt_o[gi]    = grant && (sel_idx == IDW'(gi));
    assign bus.m_rvalid_o[gi] = rsp_valid && (head_idx == IDW'(gi));
    assign bus.m_rdata_o[gi]  = (rsp_valid && (head_idx == IDW'(gi))) ? bus.s_rdata_i : '0;
  end

  cgra_arb_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (grant),
    .push_data (sel_idx),
    .pop       (rsp_valid),
    .head      (head_idx),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      locked_idx_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      // A response with nobody waiting for it is unroutable and latches the error.
      if (bus.s_rvalid_i && fifo_empty) err_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (grant) begin
            rr_ptr_reg <= next_ptr;
          end else if (s_req) begin
            state_reg      <= LOCKED;
            locked_idx_reg <= sel_idx;
          end
        end
        LOCKED: begin
          if (grant) begin
            rr_ptr_reg <= next_ptr;
            state_reg  <= IDLE;
          end else if (!req_valid) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign err_o = err_reg;

endmodule

// File: doc/cgra_ext_slave_arbiter.md
CGRA_EXT_SLAVE_ARBITER -- requirements
Module: cgra_ext_slave_arbiter

Interface
REQ-001 The block SHALL have parameter NMASTER, default CGRA_XBAR_NMASTER (8): number of CGRA OBI masters sharing the slave.
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 4: depth of the response-routing FIFO.
REQ-003 The block SHALL have port clk_i, input, 1: single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have ports m_req_i / m_gnt_o, input / output, NMASTER each: per-master OBI request and grant.
REQ-006 The block SHALL have ports m_addr_i, m_wdata_i, m_be_i, m_we_i, inputs, NMASTER x 32 / x32 / x4 / x1: per-master OBI address phase.
REQ-007 The block SHALL have ports m_rvalid_o / m_rdata_o, outputs, NMASTER / NMASTER x 32: per-master response.
REQ-008 The block SHALL have ports s_req_o, s_addr_o, s_wdata_o, s_be_o, s_we_o, outputs, 1/32/32/4/1: OBI request to the CGRA external slave (EXT_XBAR index CGRA_IDX).
REQ-009 The block SHALL have ports s_gnt_i, s_rvalid_i, s_rdata_i, inputs, 1/1/32: slave grant and response.
REQ-010 The block SHALL have port outstanding_o, output, $clog2(MAX_OUTSTANDING+1): current FIFO occupancy.
REQ-011 The block SHALL have port err_o, output, 1: sticky protocol-error flag.

Function
REQ-012 FSM states SHALL be IDLE and LOCKED.
REQ-013 In IDLE with FIFO not full: winner = first asserted m_req_i searching from rr_ptr upward, wrapping at NMASTER-1 to 0; its address phase drives s_*; s_req_o=1.
REQ-014 In IDLE with FIFO full, s_req_o=0 and all m_gnt_o=0, even if s_rvalid_i pops the FIFO that same cycle.
REQ-015 If s_req_o=1 and s_gnt_i=0, the FSM SHALL enter LOCKED, storing the winner index; in LOCKED that master alone drives s_*, regardless of other requests.
REQ-016 On s_req_o & s_gnt_i: m_gnt_o[winner]=1 combinationally in the same cycle; winner index pushed into the FIFO; rr_ptr <= (winner+1) mod NMASTER; FSM -> IDLE.
REQ-017 No request SHALL be issued while FIFO full; at most one grant per cycle.
REQ-018 On s_rvalid_i: m_rvalid_o[head]=1 and m_rdata_o[head]=s_rdata_i in the same cycle; FIFO pops; all other m_rvalid_o=0. m_rdata_o of non-selected masters SHALL be 0.
REQ-019 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-020 s_rvalid_i with FIFO empty SHALL be dropped (no m_rvalid_o) and SHALL set err_o=1 until reset.
REQ-021 Grant-to-issue latency SHALL be 0 cycles (combinational request path); response routing latency 0 cycles.
REQ-022 With no m_req_i asserted, s_req_o=0 and s_* data outputs SHALL be 0.

Reset
REQ-023 While rst_i=1 at a clock edge: FSM=IDLE, rr_ptr=0, FIFO empty, outstanding_o=0, err_o=0; s_req_o and all m_gnt_o/m_rvalid_o are 0 during reset.
REQ-024 Reset mid-transaction SHALL discard all outstanding IDs; responses arriving after reset SHALL set err_o per REQ-020.

Structure
REQ-025 NMASTER default, MAX_OUTSTANDING default and the FSM state enum SHALL live in soc_sonhamos_pkg.
REQ-026 The ID FIFO SHALL be a sub-module cgra_arb_id_fifo (width $clog2(NMASTER), depth MAX_OUTSTANDING, push/pop/full/empty/count).

Verification
REQ-027 m_req_i=8'hFF held, s_gnt_i=1, s_rvalid_i one cycle later each -> grants to masters 0,1,...,7,0 on consecutive cycles.
REQ-028 Masters 2 and 5 request, s_gnt_i=0 for 3 cycles, master 5 stays requesting -> s_addr_o stays master 2's address for 4 cycles; grant to 2, then 5.
REQ-029 Four grants with no s_rvalid_i -> outstanding_o=4, s_req_o=0 despite requests; one rvalid -> occupancy 3; the next cycle a grant issues.
REQ-030 Grants to masters 3,6,1; three rvalids with rdata 0xA,0xB,0xC -> m_rvalid_o[3]/0xA, [6]/0xB, [1]/0xC in order.
REQ-031 s_rvalid_i with empty FIFO -> no m_rvalid_o, err_o=1 held until rst_i.
REQ-032 rst_i asserted with 2 outstanding -> outstanding_o=0, rr_ptr=0; next request from master 7 alone is granted.
